// File: rtl/arm_core_pkg.sv
// Shared types and constants for the LDM/STM block-transfer sequencer.
package arm_core_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_XFER = 2'd1,
    S_WB   = 2'd2,
    S_FIN  = 2'd3
  } seq_state_e;

  localparam logic [3:0] REG_PC     = 4'd15;
  localparam int         WORD_BYTES = 4;

  function automatic logic [4:0] popcount16(input logic [15:0] v);
    logic [4:0] cnt;
    cnt = 5'd0;
    for (int i = 0; i < 16; i++) begin
      cnt = cnt + {4'd0, v[i]};
    end
    return cnt;
  endfunction

endpackage

// File: rtl/prio_enc16.sv
// Lowest-set-bit priority encoder over a 16-bit request vector.
module prio_enc16 (
  input  logic [15:0] req,
  output logic [3:0]  idx,
  output logic        valid
);

  // scan downward so the final hit left standing is the lowest index
  always_comb begin
    idx   = 4'd0;
    valid = |req;
    for (int i = 15; i >= 0; i--) begin
      idx = req[i] ? 4'(i) : idx;
    end
  end

endmodule

// File: rtl/ldm_stm_sequencer.sv
// ARM LDM/STM register-list sequencer: one memory beat per listed register, then optional base writeback.
// Build option: define LDM_EMPTY_LIST_QUIRK_EN for ARMv4 empty-list behaviour (R15 only, base offset 0x40).
module ldm_stm_sequencer
  import arm_core_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [15:0]       reg_list,
  input  logic              is_load,
  input  logic              up,
  input  logic              pre,
  input  logic              wb,
  input  logic [3:0]        base_idx,
  input  logic [ADDR_W-1:0] base_val,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [3:0]        rf_rd_idx,
  input  logic [DATA_W-1:0] rf_rd_data,
  output logic              rf_wr_en,
  output logic [3:0]        rf_wr_idx,
  output logic [DATA_W-1:0] rf_wr_data,
  output logic              busy,
  output logic              done
);

  localparam logic [ADDR_W-1:0] WORD_INC   = ADDR_W'(WORD_BYTES);
  localparam logic [ADDR_W-1:0] ALIGN_MASK = {{(ADDR_W-2){1'b1}}, 2'b00};

  seq_state_e        state_r, state_next_s;
  logic [15:0]       rem_r;
  logic [ADDR_W-1:0] addr_r;
  logic [ADDR_W-1:0] final_base_r;
  logic              is_load_r;
  logic              wb_r;
  logic              wb_block_r;
  logic [3:0]        base_idx_r;

  logic [15:0]       list_eff_s;
  logic [4:0]        n_s;
  logic [ADDR_W-1:0] off_s;
  logic [ADDR_W-1:0] start_raw_s;
  logic [ADDR_W-1:0] start_addr_s;
  logic [ADDR_W-1:0] final_base_s;
  logic [3:0]        cur_idx_s;
  logic              cur_valid_s;
  logic [15:0]       rem_clr_s;
  logic              launch_s;
  logic              beat_s;

  prio_enc16 u_prio (
    .req   (rem_r),
    .idx   (cur_idx_s),
    .valid (cur_valid_s)
  );

  // launch-time address arithmetic from the live decode inputs
  always_comb begin
    list_eff_s = reg_list;
    n_s        = popcount16(reg_list);
    off_s      = ADDR_W'({n_s, 2'b00});
`ifdef LDM_EMPTY_LIST_QUIRK_EN
    if (reg_list == 16'd0) begin
      list_eff_s = 16'd1 << REG_PC;
      off_s      = ADDR_W'(8'h40);
    end else begin
      list_eff_s = reg_list;
    end
`endif
    case ({up, pre})
      2'b10:   start_raw_s = base_val;
      2'b11:   start_raw_s = base_val + WORD_INC;
      2'b00:   start_raw_s = base_val - off_s + WORD_INC;
      2'b01:   start_raw_s = base_val - off_s;
      default: start_raw_s = base_val;
    endcase
    start_addr_s = start_raw_s & ALIGN_MASK;
    if (up) begin
      final_base_s = (base_val + off_s) & ALIGN_MASK;
    end else begin
      final_base_s = (base_val - off_s) & ALIGN_MASK;
    end
    rem_clr_s = rem_r & ~(16'd1 << cur_idx_s);
  end

  // state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // next-state and bus/register-file outputs; everything is 0 outside its active state
  always_comb begin
    state_next_s = state_r;
    launch_s     = 1'b0;
    beat_s       = 1'b0;
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    mem_addr     = '0;
    mem_wdata    = '0;
    rf_rd_idx    = 4'd0;
    rf_wr_en     = 1'b0;
    rf_wr_idx    = 4'd0;
    rf_wr_data   = '0;
    busy         = 1'b0;
    done         = 1'b0;
    case (state_r)
      S_IDLE: begin
        if (start) begin
          launch_s = 1'b1;
          if (list_eff_s != 16'd0) begin
            state_next_s = S_XFER;
          end else if (wb) begin
            state_next_s = S_WB;
          end else begin
            state_next_s = S_FIN;
          end
        end else begin
          state_next_s = S_IDLE;
        end
      end
      S_XFER: begin
        busy      = 1'b1;
        mem_req   = cur_valid_s;
        mem_we    = ~is_load_r;
        mem_addr  = addr_r;
        rf_rd_idx = cur_idx_s;
        mem_wdata = is_load_r ? '0 : rf_rd_data;
        if (!cur_valid_s) begin
          state_next_s = S_FIN;
        end else if (mem_ack) begin
          beat_s = 1'b1;
          if (is_load_r) begin
            rf_wr_en   = 1'b1;
            rf_wr_idx  = cur_idx_s;
            rf_wr_data = mem_rdata;
          end else begin
            rf_wr_en   = 1'b0;
          end
          if (rem_clr_s == 16'd0) begin
            state_next_s = wb_r ? S_WB : S_FIN;
          end else begin
            state_next_s = S_XFER;
          end
        end else begin
          state_next_s = S_XFER;
        end
      end
      S_WB: begin
        busy = 1'b1;
        // a loaded base register keeps the loaded value
        if (!wb_block_r) begin
          rf_wr_en   = 1'b1;
          rf_wr_idx  = base_idx_r;
          rf_wr_data = DATA_W'(final_base_r);
        end else begin
          rf_wr_en   = 1'b0;
        end
        state_next_s = S_FIN;
      end
      S_FIN: begin
        done         = 1'b1;
        state_next_s = S_IDLE;
      end
      default: begin
        state_next_s = S_IDLE;
      end
    endcase
  end

  // transfer context: latched at launch, advanced on every acknowledged beat
  always_ff @(posedge clk) begin
    if (rst) begin
      rem_r        <= 16'd0;
      addr_r       <= '0;
      final_base_r <= '0;
      is_load_r    <= 1'b0;
      wb_r         <= 1'b0;
      wb_block_r   <= 1'b0;
      base_idx_r   <= 4'd0;
    end else if (launch_s) begin
      rem_r        <= list_eff_s;
      addr_r       <= start_addr_s;
      final_base_r <= final_base_s;
      is_load_r    <= is_load;
      wb_r         <= wb;
      wb_block_r   <= is_load & list_eff_s[base_idx];
      base_idx_r   <= base_idx;
    end else if (beat_s) begin
      rem_r        <= rem_clr_s;
      addr_r       <= addr_r + WORD_INC;
    end else begin
      rem_r        <= rem_r;
      addr_r       <= addr_r;
    end
  end

endmodule

// File: doc/ldm_stm_sequencer.md
Name: ldm_stm_sequencer

Overview:
- Controller that sequences the core register file for ARM block transfers (LDM/STM).
- Walks a 16-bit register list lowest-index-first and issues one memory beat per register over a req/ack handshake.
- For LDM, drives the register-file write port with loaded data. For STM, drives a register-file read index and forwards the read data to memory.
- Performs base-register writeback at the end of the transfer.
- Sits between instruction decode, the register file and the memory interface.

Parameters:
- DATA_W, 32, register and memory data width.
- ADDR_W, 32, memory address width.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle launch pulse; sampled only in IDLE.
- reg_list  in  16  register bitmap; bit i selects Ri.
- is_load  in  1  1=LDM, 0=STM.
- up  in  1  U bit; 1=increment, 0=decrement.
- pre  in  1  P bit; 1=before, 0=after.
- wb  in  1  W bit; base writeback enable.
- base_idx  in  4  index of base register Rn.
- base_val  in  ADDR_W  value of Rn, sampled at start.
- mem_req  out  1  memory beat request.
- mem_we  out  1  1=store beat.
- mem_addr  out  ADDR_W  beat address, word aligned.
- mem_wdata  out  DATA_W  store data (= rf_rd_data).
- mem_ack  in  1  beat completes this cycle.
- mem_rdata  in  DATA_W  load data, valid with mem_ack.
- rf_rd_idx  out  4  register-file read index (combinational read).
- rf_rd_data  in  DATA_W  register-file read data.
- rf_wr_en  out  1  register-file write strobe.
- rf_wr_idx  out  4  register-file write index.
- rf_wr_data  out  DATA_W  register-file write data.
- busy  out  1  high from the cycle after start until done.
- done  out  1  one-cycle pulse when the sequence completes.

Behaviour:
- Reset values:
  - All outputs 0.
  - State = IDLE; latched list, count and address = 0.
  - Reset mid-sequence aborts immediately. No further beats and no base writeback.
- States: IDLE, XFER, WB, FIN.
- IDLE + start:
  - Latch reg_list, is_load, up, pre, wb, base_idx, base_val.
  - n = popcount(reg_list), width 5.
  - Start address:
    - IA (up=1, pre=0): base
    - IB (up=1, pre=1): base+4
    - DA (up=0, pre=0): base−4n+4
    - DB (up=0, pre=1): base−4n
  - Final base:
    - up=1: base+4n
    - up=0: base−4n
  - Go to XFER next cycle. Address arithmetic is modulo 2^ADDR_W; bits [1:0] are forced to 0.
- XFER:
  - cur = index of the lowest set bit of the remaining list.
  - mem_req=1; mem_addr = current address; mem_we = !is_load; rf_rd_idx = cur.
  - mem_req stays high with stable addr/we/wdata until mem_ack.
  - On mem_ack:
    - Load: rf_wr_en=1, rf_wr_idx=cur, rf_wr_data=mem_rdata in the same cycle.
    - Clear bit cur from the remaining list; address += 4.
    - If the remaining list is now empty: go to WB if wb=1, else FIN.
  - mem_req drops in the cycle after the final ack.
- WB (one cycle): rf_wr_en=1, rf_wr_idx=base_idx, rf_wr_data=final base. Exception: when is_load=1 and base_idx is in the list, WB writes nothing (loaded value wins). Then go to FIN.
- FIN (one cycle): done=1, busy=0, return to IDLE. A start in FIN is ignored; start is accepted again the following cycle.
- start while busy is ignored. Inputs other than mem_*/rf_rd_data are don't-care after the launch cycle.
- Latency: n beats plus 1 WB cycle (if wb) plus 1 FIN cycle, plus stall cycles while mem_ack is low.

Optional Feature:
- Macro: LDM_EMPTY_LIST_QUIRK_EN.
- Defined: reg_list==0 transfers R15 only (n_beats=1). Base offset is ±0x40 for both start-address and writeback computation (ARMv4 behaviour).
- Undefined: reg_list==0 issues no beats. If wb=1, WB writes base unchanged; otherwise go directly to FIN. done pulses 2 cycles after start.

Decomposition:
- Shared package (arm_core_pkg):
  - State encoding constants.
  - REG_PC=4'd15.
  - WORD_BYTES=4.
- Sub-module: prio_enc16 (lowest-set-bit index plus valid flag), reused for the remaining-list walk.

Test Plan:
- LDMIA, base=0x1000, list=0x000B, wb=1, ack every cycle → beats at 0x1000/0x1004/0x1008 write R0/R1/R3; WB writes R(base_idx)=0x100C; done 5 cycles after start.
- STMDB, base=0x2000, list=0x4010 (R4, R14), wb=1 → mem_we=1; addr 0x1FF8 (rd_idx 4) then 0x1FFC (rd_idx 14); WB 0x1FF8.
- LDMIB with base in list: base_idx=2, list=0x0006, base=0x100 → R1←[0x104], R2←[0x108], no WB write.
- Stall: mem_ack low for 3 cycles on the 2nd beat → mem_req, mem_addr and mem_wdata held stable; no rf_wr_en until ack.
- Reset asserted in the middle of a 4-beat LDM → next cycle all outputs 0, no WB, IDLE; a new start is accepted the cycle after reset deasserts.
- Empty list, wb=1, base=0x3000:
  - With LDM_EMPTY_LIST_QUIRK_EN: one beat R15@0x3000, base→0x3040.
  - Without: zero beats, WB writes 0x3000.
